add_sequencer32: RTL and testbench
==================================

ADD_SEQUENCER32 -- requirements
Module: add_sequencer32

Interface
REQ-001 SHALL have parameter WORDS, default 4, number of 8-bit slices per operand (legal 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 SHALL have port a  input  8*WORDS  operand A, captured at accepted start.
REQ-006 SHALL have port b  input  8*WORDS  operand B, captured at accepted start.
REQ-007 SHALL have port carryIn  input  1  initial carry for add, captured at accepted start.
REQ-008 SHALL have port op  input  1  0 = add, 1 = subtract; present only with ADD_SEQ_SUB_EN.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-011 SHALL have port sum  output  8*WORDS  result, held until next accepted start.
REQ-012 SHALL have port carryOut  output  1  carry out of the top slice.
REQ-013 SHALL have port overflow  output  1  signed overflow of the full-width result.

Function
REQ-014 SHALL contain exactly one 8-bit ripple-carry adder instance, time-shared across all slices, least significant slice first.
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after slice WORDS-1, DONE->IDLE next cycle unless start, DONE->RUN on start.
REQ-016 SHALL, on accepted start, latch a, b, carryIn and op, clear slice index to 0 and load carry register with initial carry.
REQ-017 SHALL, in each RUN cycle k, add slice k of A, slice k of (effective) B and carry register, write sum slice k, store adder carry in carry register, increment k.
REQ-018 SHALL assert done exactly WORDS+1 rising edges after the edge sampling start, for one cycle (DONE state).
REQ-019 SHALL update sum slices in place during RUN; sum is only valid when done or after DONE until next accepted start.
REQ-020 SHALL set carryOut to final carry register value and overflow to (carry into bit 8*WORDS-1) XOR (carry out of it), both registered at entry to DONE.
REQ-021 SHALL ignore start while busy; operands and progress unaffected.
REQ-022 SHALL, on start held continuously, begin a new operation from every DONE cycle (back-to-back throughput of one result per WORDS+1 cycles).
REQ-023 SHALL keep slice index wrap-free: index never exceeds WORDS-1.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-RUN, enter IDLE immediately and drive busy=0, done=0, sum=0, carryOut=0, overflow=0, carry register=0, slice index=0.
REQ-025 SHALL not accept start in the cycle in which reset is deasserting if reset is still high at the sampling edge.

Configuration
REQ-026 SHALL recognise macro ADD_SEQ_SUB_EN.
REQ-027 SHALL, with ADD_SEQ_SUB_EN defined, provide op; op=1 inverts every B slice and forces initial carry to 1 (carryIn ignored); carryOut=1 means no borrow.
REQ-028 SHALL, without ADD_SEQ_SUB_EN, omit op and perform addition only with initial carry = carryIn.

Verification (WORDS=4)
REQ-029 SHALL cover: a=0xFFFFFFFF, b=0x00000001, carryIn=0, start -> done 5 edges later, sum=0x00000000, carryOut=1, overflow=0.
REQ-030 SHALL cover: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, carryOut=0, overflow=1.
REQ-031 SHALL cover (ADD_SEQ_SUB_EN): op=1, a=5, b=7 -> sum=0xFFFFFFFE, carryOut=0, overflow=0.
REQ-032 SHALL cover: start pulsed again at cycle 2 of RUN with different operands -> ignored, first result unchanged, single done pulse.
REQ-033 SHALL cover: reset asserted at RUN cycle 2 -> busy, sum, carryOut immediately 0; new start after release yields correct result with normal latency.
REQ-034 SHALL cover: start held high for 3 operations -> done pulses spaced exactly 5 cycles, each sum correct.

Source files
------------

// File: rtl/add_sequencer32.sv
// -----------------------------------------------------------------------------
// add_sequencer32
//
// Purpose
//   Multi-cycle adder that produces an (8*WORDS)-bit sum using one 8-bit
//   ripple-carry adder, reused once per 8-bit slice, least significant slice
//   first. An operation takes WORDS cycles in RUN, followed by one DONE cycle.
//
// Parameters
//   WORDS      number of 8-bit slices per operand (legal 2..8)
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   request a new operation (looked at only in IDLE or DONE)
//   a, b       in   operands, 8*WORDS bits, captured when start is accepted
//   carryIn    in   initial carry for addition, captured with the operands
//   op         in   0 = add, 1 = subtract (only when ADD_SEQ_SUB_EN is defined)
//   busy       out  high while the slices are being processed (RUN)
//   done       out  one-cycle pulse, result fields valid
//   sum        out  result, held until the next accepted start
//   carryOut   out  carry out of the top slice (for subtract: 1 = no borrow)
//   overflow   out  signed overflow of the full-width result
//   state_dbg  out  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Configuration
//   ADD_SEQ_SUB_EN  when defined, adds the op port and subtract support.
//                   Without it the block only adds, using carryIn.
//
// Handshake
//   start is a request with no ready signal: it is accepted on any rising
//   edge where the FSM is in IDLE or DONE and reset is low. While busy is
//   high start is ignored. done is high for exactly the one cycle after the
//   last slice has been written; sum/carryOut/overflow are valid from then
//   until the next accepted start. Holding start high restarts from every
//   DONE cycle, giving one result every WORDS+1 cycles.
// -----------------------------------------------------------------------------

// 8-bit ripple-carry adder. Also exports the carry into bit 7 so the parent
// can derive signed overflow of the top slice.
module add_seq_rca8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] s,
    output logic       c_msb_in,
    output logic       cout
);

    always_comb begin
        logic [8:0] c;
        c    = 9'd0;
        s    = 8'd0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        c_msb_in = c[7];
        cout     = c[8];
    end

endmodule

module add_sequencer32 #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*WORDS-1:0]   a,
    input  logic [8*WORDS-1:0]   b,
    input  logic                 carryIn,
`ifdef ADD_SEQ_SUB_EN
    input  logic                 op,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [8*WORDS-1:0]   sum,
    output logic                 carryOut,
    output logic                 overflow,
    output logic [1:0]           state_dbg
);

    localparam int W  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    state_q,     state_d;
    logic [IW-1:0] idx_q,       idx_d;
    logic [W-1:0]  a_q,         a_d;
    logic [W-1:0]  b_q,         b_d;      // B already in its effective form
    logic          carry_q,     carry_d;
    logic [W-1:0]  sum_q,       sum_d;
    logic          carry_out_q, carry_out_d;
    logic          overflow_q,  overflow_d;

    // -------------------------------------------------------------------------
    // Operand conditioning at capture time. Subtraction is A + ~B + 1, so the
    // inversion and the forced carry are applied once, when operands are
    // latched, and the slice datapath stays a plain adder.
    // -------------------------------------------------------------------------
    logic [W-1:0] b_eff;
    logic         cin_init;

    always_comb begin
`ifdef ADD_SEQ_SUB_EN
        b_eff    = op ? ~b : b;
        cin_init = op ? 1'b1 : carryIn;
`else
        b_eff    = b;
        cin_init = carryIn;
`endif
    end

    // -------------------------------------------------------------------------
    // Slice selection feeding the single shared adder.
    // -------------------------------------------------------------------------
    logic [7:0] a_slice;
    logic [7:0] b_slice;

    always_comb begin
        a_slice = 8'd0;
        b_slice = 8'd0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                a_slice = a_q[i*8 +: 8];
                b_slice = b_q[i*8 +: 8];
            end
        end
    end

    logic [7:0] add_s;
    logic       add_c_msb_in;
    logic       add_cout;

    add_seq_rca8 u_rca (
        .x        (a_slice),
        .y        (b_slice),
        .cin      (carry_q),
        .s        (add_s),
        .c_msb_in (add_c_msb_in),
        .cout     (add_cout)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_init;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                // Sum slices are written in place; upper slices still hold
                // stale data until their turn comes.
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*8 +: 8] = add_s;
                    end
                end
                carry_d = add_cout;

                if (idx_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    idx_d       = '0;
                    carry_out_d = add_cout;
                    // Top slice: carry into the sign bit vs carry out of it.
                    overflow_d  = add_c_msb_in ^ add_cout;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carryOut  = carry_out_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_add_sequencer32.sv
// -----------------------------------------------------------------------------
// tb_add_sequencer32
//
// Directed test of add_sequencer32 with WORDS = 4. Inputs are driven on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// Latency is counted in rising edges, including the edge that samples start:
// done must be visible after the fifth such edge.
// -----------------------------------------------------------------------------
module tb_add_sequencer32;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryIn;
`ifdef ADD_SEQ_SUB_EN
    logic         op_s;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carryOut;
    logic         overflow;
    logic [1:0]   state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    add_sequencer32 #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .carryIn   (carryIn),
`ifdef ADD_SEQ_SUB_EN
        .op        (op_s),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carryOut  (carryOut),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    // Presents operands with start on a falling edge, lets the next rising
    // edge sample them, then drops start.
    task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cin);
        @(negedge clk);
        a       = av;
        b       = bv;
        carryIn = cin;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Waits for done; edge_no is the rising-edge count including the start
    // sampling edge (so_far edges already elapsed). -1 means timeout.
    task automatic wait_done(input int so_far, output int edge_no);
        edge_no = so_far;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (done === 1'b1) return;
        end
        edge_no = -1;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b1;
        a       = '1;
        b       = '1;
        carryIn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sum !== 32'h0) begin failures++; $display("FAIL reset_sum: got %h want 00000000", sum); end
        checks++; if (carryOut !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b want 0", carryOut); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept: busy got %b want 0", busy); end
    endtask

    task automatic test_add_vectors();
        logic [W-1:0] va   [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0000};
        logic [W-1:0] vb   [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0FED_CBA9, 32'h8000_0000};
        logic         vci  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] vsum [4] = '{32'h0000_0000, 32'h8000_0000, 32'h2222_2222, 32'h0000_0000};
        logic         vco  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic         vov  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int e;
        for (int i = 0; i < 4; i++) begin
            drive_start(va[i], vb[i], vci[i]);
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add%0d_busy: got %b want 1", i, busy); end
            wait_done(1, e);
            checks++; if (e != 5) begin failures++; $display("FAIL add%0d_latency: got %0d want 5", i, e); end
            checks++; if (sum !== vsum[i]) begin failures++; $display("FAIL add%0d_sum: got %h want %h", i, sum, vsum[i]); end
            checks++; if (carryOut !== vco[i]) begin failures++; $display("FAIL add%0d_cout: got %b want %b", i, carryOut, vco[i]); end
            checks++; if (overflow !== vov[i]) begin failures++; $display("FAIL add%0d_ovf: got %b want %b", i, overflow, vov[i]); end
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL add%0d_pulse: done got %b want 0", i, done); end
            checks++; if (sum !== vsum[i]) begin failures++; $display("FAIL add%0d_hold: got %h want %h", i, sum, vsum[i]); end
        end
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_subtract();
        int e;
        op_s = 1'b1;
        drive_start(32'd5, 32'd7, 1'b0);
        wait_done(1, e);
        checks++; if (e != 5) begin failures++; $display("FAIL sub0_latency: got %0d want 5", e); end
        checks++; if (sum !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub0_sum: got %h want fffffffe", sum); end
        checks++; if (carryOut !== 1'b0) begin failures++; $display("FAIL sub0_cout: got %b want 0", carryOut); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sub0_ovf: got %b want 0", overflow); end
        drive_start(32'd7, 32'd5, 1'b0);
        wait_done(1, e);
        checks++; if (sum !== 32'd2) begin failures++; $display("FAIL sub1_sum: got %h want 00000002", sum); end
        checks++; if (carryOut !== 1'b1) begin failures++; $display("FAIL sub1_cout: got %b want 1", carryOut); end
        op_s = 1'b0;
    endtask
`endif

    task automatic test_ignore_start();
        int e;
        int extra;
        drive_start(32'd1, 32'd2, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a     = 32'hAAAA_AAAA;
        b     = 32'h5555_5555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(4, e);
        checks++; if (e != 5) begin failures++; $display("FAIL ignore_latency: got %0d want 5", e); end
        checks++; if (sum !== 32'd3) begin failures++; $display("FAIL ignore_sum: got %h want 00000003", sum); end
        extra = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL ignore_pulses: got %0d extra done want 0", extra); end
        checks++; if (sum !== 32'd3) begin failures++; $display("FAIL ignore_hold: got %h want 00000003", sum); end
    endtask

    task automatic test_reset_mid_run();
        int e;
        drive_start(32'hFFFF_FFFF, 32'h1, 1'b0);
        wait_done(1, e);
        checks++; if (carryOut !== 1'b1) begin failures++; $display("FAIL rst_pre_cout: got %b want 1", carryOut); end
        drive_start(32'h0101_0101, 32'h0202_0202, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (sum !== 32'h0000_0303) begin failures++; $display("FAIL rst_partial_sum: got %h want 00000303", sum); end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (sum !== 32'h0) begin failures++; $display("FAIL rst_sum: got %h want 00000000", sum); end
        checks++; if (carryOut !== 1'b0) begin failures++; $display("FAIL rst_cout: got %b want 0", carryOut); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
        @(posedge clk);
        #1;
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rst_held_state: got %0d want 0", state_dbg); end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        drive_start(32'h0000_FFFF, 32'h1, 1'b0);
        wait_done(1, e);
        checks++; if (e != 5) begin failures++; $display("FAIL rst_after_latency: got %0d want 5", e); end
        checks++; if (sum !== 32'h0001_0000) begin failures++; $display("FAIL rst_after_sum: got %h want 00010000", sum); end
        checks++; if (carryOut !== 1'b0) begin failures++; $display("FAIL rst_after_cout: got %b want 0", carryOut); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        logic         exp_c[$];
        logic [W-1:0] exp_s;
        logic         exp_co;
        int           done_cyc [3];
        logic         got;

        @(negedge clk);
        a       = 32'h1111_1111;
        b       = 32'h2222_2222;
        carryIn = 1'b0;
        start   = 1'b1;
        exp_q.push_back(32'h3333_3333); exp_c.push_back(1'b0);
        @(posedge clk);
        #1;
        a = 32'hFFFF_0000;
        b = 32'h0001_0000;
        exp_q.push_back(32'h0000_0000); exp_c.push_back(1'b1);

        for (int i = 0; i < 3; i++) begin
            got = 1'b0;
            for (int n = 0; n < 12; n++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            checks++; if (got !== 1'b1) begin failures++; $display("FAIL b2b%0d_timeout: done got 0 want 1", i); end
            done_cyc[i] = cyc;
            exp_s  = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            exp_co = (exp_c.size() > 0) ? exp_c.pop_front() : 1'bx;
            checks++; if (sum !== exp_s) begin failures++; $display("FAIL b2b%0d_sum: got %h want %h", i, sum, exp_s); end
            checks++; if (carryOut !== exp_co) begin failures++; $display("FAIL b2b%0d_cout: got %b want %b", i, carryOut, exp_co); end
            if (i == 0) begin
                @(posedge clk);
                #1;
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart: busy got %b want 1", busy); end
                a = 32'h0000_007F;
                b = 32'h0000_0081;
                exp_q.push_back(32'h0000_0100); exp_c.push_back(1'b0);
            end
            if (i == 2) start = 1'b0;
        end
        checks++; if (done_cyc[1] - done_cyc[0] != 5) begin failures++; $display("FAIL b2b_spacing01: got %0d want 5", done_cyc[1] - done_cyc[0]); end
        checks++; if (done_cyc[2] - done_cyc[1] != 5) begin failures++; $display("FAIL b2b_spacing12: got %0d want 5", done_cyc[2] - done_cyc[1]); end
        @(posedge clk);
        #1;
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL b2b_idle: state got %0d want 0", state_dbg); end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and final report
    // -------------------------------------------------------------------------
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        carryIn = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        op_s    = 1'b0;
`endif
        test_reset();
        test_add_vectors();
`ifdef ADD_SEQ_SUB_EN
        test_subtract();
`endif
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
